// File: rtl/core_host_sequencer.sv
// core_host_sequencer: initiator for the core instruction-packet port.
// Loads x-mem from in_*, pulses start, waits on core_busy, streams psum
// back on rd_*. Ports: clk/reset, cmd_start + cfg_*, in_*, inst/D_xmem,
// run-config outs, core_busy/psum_mem_out, rd_*, busy/done/err_timeout.
module core_host_sequencer #(
  parameter int bw          = 4,
  parameter int col         = 8,
  parameter int psum_bw     = 13,
  parameter int ADDR_W      = 11,
  parameter int inst_bw     = ADDR_W + 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_start,
  input  logic [ADDR_W-1:0]        cfg_load_base,
  input  logic [ADDR_W-1:0]        cfg_rd_base,
  input  logic [ADDR_W:0]          cfg_load_count,
  input  logic [ADDR_W:0]          cfg_rd_count,
  input  logic [7:0]               cfg_nij,
  input  logic [7:0]               cfg_kij,
  input  logic [ADDR_W-1:0]        cfg_wt_addr,
  input  logic [ADDR_W-1:0]        cfg_act_addr,
  input  logic                     cfg_debug,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bw*col-1:0]        in_data,
  output logic [inst_bw-1:0]       inst,
  output logic [bw*col-1:0]        D_xmem,
  output logic [7:0]               num_nij_to_compute,
  output logic [7:0]               num_kij_to_compute,
  output logic [ADDR_W-1:0]        weight_start_sram_addr,
  output logic [ADDR_W-1:0]        activation_start_sram_addr,
  input  logic                     core_busy,
  input  logic [psum_bw*col-1:0]   psum_mem_out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [psum_bw*col-1:0]   rd_data,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, READ, DONE
  } state_t;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t state, state_d;

  logic [ADDR_W:0]          ld_left, rd_left;
  logic [ADDR_W-1:0]        ld_addr, rd_ptr;
  logic [ADDR_W-1:0]        wr_addr_q, cap_addr;
  logic                     wr_q, cap_q, dbg_q, err_q;
  logic [TW-1:0]            to_cnt;
  logic [psum_bw*col-1:0]   f_data [2];
  logic [ADDR_W-1:0]        f_addr [2];
  logic                     f_wp, f_rp;
  logic [1:0]               f_occ, f_occ_d;
  logic                     accept, ld_hs, issue, pop, timeout;

  assign accept   = (state == IDLE) && cmd_start;
  assign in_ready = (state == LOAD) && (ld_left != '0);
  assign ld_hs    = in_valid && in_ready;
  assign rd_valid = (f_occ != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = f_data[f_rp];
  assign rd_addr  = f_addr[f_rp];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err_timeout = err_q;

  // Occupancy after this edge; a read issued now lands one cycle later,
  // so a slot must be free even if nothing else is popped.
  assign f_occ_d = f_occ + {1'b0, cap_q} - {1'b0, pop};
  assign issue   = (state == READ) && (rd_left != '0) && !f_occ_d[1];
  assign timeout = (state == WAIT_ACK) && !core_busy &&
                   (to_cnt == TO_LAST);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (cmd_start)
          state_d = (cfg_load_count != '0) ? LOAD : START;
      LOAD:
        if (ld_left == '0) state_d = START;
      START:
        state_d = WAIT_ACK;
      WAIT_ACK:
        if (core_busy) state_d = WAIT_DONE;
        else if (timeout) state_d = DONE;
      WAIT_DONE:
        if (!core_busy)
          state_d = (rd_left != '0) ? READ : DONE;
      READ:
        if (rd_left == '0 && !cap_q && f_occ_d == 2'd0)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Decoded from registers only, so reset clears it immediately.
  always_comb begin
    inst = '0;
    unique case (1'b1)
      wr_q:
        inst = {4'b0001, wr_addr_q};
      (state == START):
        inst = {dbg_q, 3'b100, {ADDR_W{1'b0}}};
      (state == WAIT_ACK || state == WAIT_DONE):
        inst = {dbg_q, 3'b000, {ADDR_W{1'b0}}};
      issue:
        inst = {4'b0010, rd_ptr};
      default:
        inst = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ld_left    <= '0;
      rd_left    <= '0;
      ld_addr    <= '0;
      rd_ptr     <= '0;
      wr_addr_q  <= '0;
      cap_addr   <= '0;
      wr_q       <= 1'b0;
      cap_q      <= 1'b0;
      dbg_q      <= 1'b0;
      err_q      <= 1'b0;
      to_cnt     <= '0;
      D_xmem     <= '0;
      f_data[0]  <= '0;
      f_data[1]  <= '0;
      f_addr[0]  <= '0;
      f_addr[1]  <= '0;
      f_wp       <= 1'b0;
      f_rp       <= 1'b0;
      f_occ      <= 2'd0;
      num_nij_to_compute         <= '0;
      num_kij_to_compute         <= '0;
      weight_start_sram_addr     <= '0;
      activation_start_sram_addr <= '0;
    end else begin
      state  <= state_d;
      wr_q   <= ld_hs;
      D_xmem <= ld_hs ? in_data : '0;
      if (ld_hs) begin
        wr_addr_q <= ld_addr;
        ld_addr   <= ld_addr + 1'b1;
        ld_left   <= ld_left - 1'b1;
      end
      cap_q <= issue;
      if (issue) begin
        cap_addr <= rd_ptr;
        rd_ptr   <= rd_ptr + 1'b1;
        rd_left  <= rd_left - 1'b1;
      end
      if (cap_q) begin
        f_data[f_wp] <= psum_mem_out;
        f_addr[f_wp] <= cap_addr;
        f_wp         <= ~f_wp;
      end
      if (pop) f_rp <= ~f_rp;
      f_occ  <= f_occ_d;
      to_cnt <= (state == WAIT_ACK) ? to_cnt + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
      if (accept) begin
        err_q   <= 1'b0;
        dbg_q   <= cfg_debug;
        ld_left <= cfg_load_count;
        ld_addr <= cfg_load_base;
        rd_left <= cfg_rd_count;
        rd_ptr  <= cfg_rd_base;
        num_nij_to_compute         <= cfg_nij;
        num_kij_to_compute         <= cfg_kij;
        weight_start_sram_addr     <= cfg_wt_addr;
        activation_start_sram_addr <= cfg_act_addr;
      end
    end
  end

endmodule

// File: tb/tb_core_host_sequencer.sv
// tb_core_host_sequencer: directed bench with a core/psum model and
// scoreboard queues for x-mem writes, start pulses and readback beats.
module tb_core_host_sequencer;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int PW = 13 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_start;
  logic [AW-1:0] cfg_load_base, cfg_rd_base;
  logic [AW:0]   cfg_load_count, cfg_rd_count;
  logic [7:0]    cfg_nij, cfg_kij;
  logic [AW-1:0] cfg_wt_addr, cfg_act_addr;
  logic          cfg_debug;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [AW+3:0] inst;
  logic [DW-1:0] D_xmem;
  logic [7:0]    num_nij_to_compute, num_kij_to_compute;
  logic [AW-1:0] weight_start_sram_addr, activation_start_sram_addr;
  logic          core_busy;
  logic [PW-1:0] psum_mem_out = '0;
  logic          rd_valid, rd_ready;
  logic [PW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy, done, err_timeout;

  core_host_sequencer dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start),
    .cfg_load_base(cfg_load_base), .cfg_rd_base(cfg_rd_base),
    .cfg_load_count(cfg_load_count), .cfg_rd_count(cfg_rd_count),
    .cfg_nij(cfg_nij), .cfg_kij(cfg_kij),
    .cfg_wt_addr(cfg_wt_addr), .cfg_act_addr(cfg_act_addr),
    .cfg_debug(cfg_debug),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inst(inst), .D_xmem(D_xmem),
    .num_nij_to_compute(num_nij_to_compute),
    .num_kij_to_compute(num_kij_to_compute),
    .weight_start_sram_addr(weight_start_sram_addr),
    .activation_start_sram_addr(activation_start_sram_addr),
    .core_busy(core_busy), .psum_mem_out(psum_mem_out),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] wq [$];
  logic [16:0]      sq [$];
  logic [AW+PW-1:0] rq [$];
  int rd_inst_cnt = 0;
  int done_cnt    = 0;

  logic [AW+DW-1:0] we;
  logic [16:0]      se;
  logic [AW+PW-1:0] re;
  logic             hold_q = 1'b0;
  logic [AW-1:0]    hold_addr;
  logic [PW-1:0]    hold_data;

  logic busy_en = 1'b1;
  int   t = 0;

  function automatic logic [PW-1:0] psum_fn(input logic [AW-1:0] a);
    return {8{2'b01, a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core model: psum read data one cycle after a read inst; core_busy
  // rises 3 cycles after the start pulse and stays high 50 cycles.
  always @(posedge clk) begin
    if (inst[AW+1]) psum_mem_out <= psum_fn(inst[AW-1:0]);
    if (inst[AW+2] && busy_en) t <= 1;
    else if (t != 0) t <= (t == 52) ? 0 : t + 1;
  end
  assign core_busy = (t >= 3);

  always @(negedge clk) begin
    if (reset) begin
      if (inst[AW]) begin
        if (wq.size() == 0) chk("wr_unexpected", 128'(inst), 128'(0));
        else begin
          we = wq.pop_front();
          chk("wr_inst", 128'(inst), 128'({4'b0001, we[AW+DW-1:DW]}));
          chk("wr_data", 128'(D_xmem), 128'(we[DW-1:0]));
        end
      end
      if (inst[AW+2]) begin
        if (sq.size() == 0) chk("start_unexpected", 128'(inst), 128'(0));
        else begin
          se = sq.pop_front();
          chk("start_inst", 128'(inst),
              128'({se[16], 3'b100, {AW{1'b0}}}));
          chk("start_nij", 128'(num_nij_to_compute), 128'(se[15:8]));
          chk("start_kij", 128'(num_kij_to_compute), 128'(se[7:0]));
        end
      end
      if (inst[AW+1]) rd_inst_cnt++;
      if (hold_q) begin
        chk("rd_hold_addr", 128'(rd_addr), 128'(hold_addr));
        chk("rd_hold_data", 128'(rd_data), 128'(hold_data));
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rd_unexpected", 128'(rd_addr), 128'(0));
        else begin
          re = rq.pop_front();
          chk("rd_addr", 128'(rd_addr), 128'(re[AW+PW-1:PW]));
          chk("rd_data", 128'(rd_data), 128'(re[PW-1:0]));
        end
      end
      hold_q    <= rd_valid && !rd_ready;
      hold_addr <= rd_addr;
      hold_data <= rd_data;
      if (done) done_cnt++;
    end
  end

  task automatic start_run(input logic [AW-1:0] lb, input logic [AW:0] lc,
                           input logic [AW-1:0] rb, input logic [AW:0] rc,
                           input logic [7:0] nij, input logic [7:0] kij,
                           input logic dbg, input logic exp_rd);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    cfg_load_base  = lb;
    cfg_load_count = lc;
    cfg_rd_base    = rb;
    cfg_rd_count   = rc;
    cfg_nij        = nij;
    cfg_kij        = kij;
    cfg_debug      = dbg;
    cfg_wt_addr    = rb ^ 11'h155;
    cfg_act_addr   = lb ^ 11'h2AA;
    cmd_start      = 1'b1;
    sq.push_back({dbg, nij, kij});
    if (exp_rd)
      for (int i = 0; i < int'(rc); i++) begin
        a = rb + AW'(i);
        rq.push_back({a, psum_fn(a)});
      end
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    wq.push_back({a, d});
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic rnd);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("done_seen", 128'(done), 128'(1));
    @(posedge clk); #1;
    rd_ready = 1'b1;
    chk("idle_after_done", 128'(busy), 128'(0));
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_wq"}, 128'(wq.size()), 128'(0));
    chk({tag, "_sq"}, 128'(sq.size()), 128'(0));
    chk({tag, "_rq"}, 128'(rq.size()), 128'(0));
  endtask

  initial begin
    int n, d0, r0;
    reset = 1'b0; cmd_start = 1'b0; cfg_debug = 1'b0;
    cfg_load_base = '0; cfg_rd_base = '0;
    cfg_load_count = '0; cfg_rd_count = '0;
    cfg_nij = '0; cfg_kij = '0; cfg_wt_addr = '0; cfg_act_addr = '0;
    in_valid = 1'b0; in_data = '0; rd_ready = 1'b1;
    #8;
    chk("rst_inst", 128'(inst), 128'(0));
    chk("rst_dxmem", 128'(D_xmem), 128'(0));
    chk("rst_nij", 128'(num_nij_to_compute), 128'(0));
    chk("rst_wt", 128'(weight_start_sram_addr), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err_timeout), 128'(0));
    #4 reset = 1'b1;

    // Four-word load, busy handshake, three-beat readback.
    d0 = done_cnt;
    start_run(11'h010, 12'd4, 11'h020, 12'd3, 8'd36, 8'd9, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      send_word(11'h010 + AW'(i), 32'h1111_1111 * DW'(i + 1));
    n = 0;
    while (!core_busy && n < 30) begin @(posedge clk); #1; n++; end
    chk("core_busy_seen", 128'(core_busy), 128'(1));
    cfg_nij = 8'd99;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    chk("ignored_start_nij", 128'(num_nij_to_compute), 128'(36));
    chk("ignored_start_busy", 128'(busy), 128'(1));
    wait_done(200, 1'b0);
    chk("run1_done_once", 128'(done_cnt - d0), 128'(1));
    chk("run1_wt_addr", 128'(weight_start_sram_addr), 128'(11'h020 ^ 11'h155));
    chk("run1_act_addr", 128'(activation_start_sram_addr), 128'(11'h010 ^ 11'h2AA));
    queues_empty("run1");

    // No load, no read: start is the cycle after cmd_start.
    start_run(11'h000, 12'd0, 11'h000, 12'd0, 8'd5, 8'd6, 1'b0, 1'b1);
    chk("start_next_cycle", 128'(inst[AW+2]), 128'(1));
    wait_done(100, 1'b0);
    queues_empty("run0");

    // core_busy never rises.
    busy_en = 1'b0;
    r0 = rd_inst_cnt;
    d0 = done_cnt;
    start_run(11'h000, 12'd0, 11'h030, 12'd2, 8'd7, 8'd3, 1'b1, 1'b0);
    chk("to_start_inst", 128'(inst), 128'({4'b1100, {AW{1'b0}}}));
    n = 0;
    while (!err_timeout && n < 40) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", 128'(n), 128'(16));
    chk("timeout_done", 128'(done), 128'(1));
    wait_done(10, 1'b0);
    chk("timeout_no_read", 128'(rd_inst_cnt - r0), 128'(0));
    chk("timeout_done_once", 128'(done_cnt - d0), 128'(1));
    chk("timeout_sticky", 128'(err_timeout), 128'(1));
    queues_empty("run_to");
    busy_en = 1'b1;

    // Wrapping load and readback with a stalling consumer.
    start_run(11'h7FF, 12'd2, 11'h7FD, 12'd5, 8'd12, 8'd4, 1'b0, 1'b1);
    chk("err_cleared", 128'(err_timeout), 128'(0));
    send_word(11'h7FF, 32'hA5A5_0001);
    send_word(11'h000, 32'h5A5A_0002);
    wait_done(400, 1'b1);
    queues_empty("run2");

    // Reset in the middle of a load.
    start_run(11'h200, 12'd4, 11'h040, 12'd1, 8'd8, 8'd8, 1'b0, 1'b1);
    send_word(11'h200, 32'hDEAD_0000);
    send_word(11'h201, 32'hDEAD_0001);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_0002;
    chk("pre_reset_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_write", 128'(inst), 128'({4'b0001, 11'h202}));
    #1 reset = 1'b0;
    #1;
    chk("reset_inst", 128'(inst), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_nij", 128'(num_nij_to_compute), 128'(0));
    sq.delete();
    rq.delete();
    #20 reset = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_idle", 128'(busy), 128'(0));
    chk("after_reset_inst", 128'(inst), 128'(0));
    queues_empty("rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
